seq_scan_ctrl: RTL and testbench

SEQ_SCAN_CTRL -- requirements
Module: seq_scan_ctrl

---
 rtl/seq_scan_ctrl.sv | 124 ++++++++++++
 tb/tb_seq_scan_ctrl.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/seq_scan_ctrl.sv
// Serial pattern scanner: accepts up to 16 bytes per job, shifts them MSB first
// into a 4-bit history and counts every (overlapping) match of a 1..4 bit pattern.
`timescale 1ns/1ps
module seq_scan_ctrl (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic [3:0] cfg_pat,
  input  logic [2:0] cfg_len,
  input  logic [3:0] cfg_nbytes,
  input  logic [7:0] byte_in,
  input  logic       byte_valid,
  output logic       byte_ready,
  output logic       hit,
  output logic [7:0] hit_cnt,
  output logic       busy,
  output logic       done
);

  // Byte handshake: a byte transfers on a rising edge where byte_valid and
  // byte_ready are both 1; byte_ready is high for every cycle spent in LOAD.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    SHIFT = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t     state;
  logic [3:0] pat_r;
  logic [2:0] len_r;
  logic [4:0] nbytes_r;
  logic [4:0] byte_cnt;
  logic [2:0] bit_cnt;
  logic [2:0] bv_cnt;
  logic [3:0] hist;
  logic [7:0] sreg;

  logic [2:0] len_eff;
  logic [4:0] nbytes_eff;
  logic [3:0] new_hist;
  logic [2:0] new_bv;
  logic [3:0] len_mask;
  logic       match;

  always_comb begin
    len_eff    = (cfg_len >= 3'd1 && cfg_len <= 3'd4) ? cfg_len : 3'd4;
    nbytes_eff = (cfg_nbytes == 4'd0) ? 5'd16 : {1'b0, cfg_nbytes};
  end

  // Match is judged on the history as it will look after this cycle's shift.
  always_comb begin
    new_hist = {hist[2:0], sreg[7]};
    new_bv   = (bv_cnt == 3'd4) ? 3'd4 : bv_cnt + 3'd1;
    case (len_r)
      3'd1:    len_mask = 4'b0001;
      3'd2:    len_mask = 4'b0011;
      3'd3:    len_mask = 4'b0111;
      default: len_mask = 4'b1111;
    endcase
    match = (((new_hist ^ pat_r) & len_mask) == 4'd0) && (new_bv >= len_r);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      pat_r    <= 4'd0;
      len_r    <= 3'd0;
      nbytes_r <= 5'd0;
      byte_cnt <= 5'd0;
      bit_cnt  <= 3'd0;
      bv_cnt   <= 3'd0;
      hist     <= 4'd0;
      sreg     <= 8'd0;
      hit      <= 1'b0;
      hit_cnt  <= 8'd0;
    end else begin
      hit <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            pat_r    <= cfg_pat;
            len_r    <= len_eff;
            nbytes_r <= nbytes_eff;
            byte_cnt <= 5'd0;
            bit_cnt  <= 3'd0;
            bv_cnt   <= 3'd0;
            hist     <= 4'd0;
            hit_cnt  <= 8'd0;
            state    <= LOAD;
          end
        end
        LOAD: begin
          if (byte_valid) begin
            sreg     <= byte_in;
            byte_cnt <= byte_cnt + 5'd1;
            bit_cnt  <= 3'd0;
            state    <= SHIFT;
          end
        end
        SHIFT: begin
          hist    <= new_hist;
          bv_cnt  <= new_bv;
          sreg    <= {sreg[6:0], 1'b0};
          bit_cnt <= bit_cnt + 3'd1;
          if (match) begin
            hit <= 1'b1;
            if (hit_cnt != 8'hFF) hit_cnt <= hit_cnt + 8'd1;
          end
          if (bit_cnt == 3'd7) state <= (byte_cnt == nbytes_r) ? DONE : LOAD;
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  always_comb begin
    byte_ready = (state == LOAD);
    busy       = (state == LOAD) || (state == SHIFT);
    done       = (state == DONE);
  end

endmodule

// File: tb/tb_seq_scan_ctrl.sv
// Bench for seq_scan_ctrl: per-cycle expectations derived from each job's bit stream.
`timescale 1ns/1ps
module tb_seq_scan_ctrl;

  // ---------------- clock / reset ----------------
  logic       clk = 1'b0;
  logic       rst_n;
  logic       start;
  logic [3:0] cfg_pat;
  logic [2:0] cfg_len;
  logic [3:0] cfg_nbytes;
  logic [7:0] byte_in;
  logic       byte_valid;
  logic       byte_ready;
  logic       hit;
  logic [7:0] hit_cnt;
  logic       busy;
  logic       done;

  always #5 clk = ~clk;

  seq_scan_ctrl dut (
    .clk(clk), .rst_n(rst_n), .start(start), .cfg_pat(cfg_pat),
    .cfg_len(cfg_len), .cfg_nbytes(cfg_nbytes), .byte_in(byte_in),
    .byte_valid(byte_valid), .byte_ready(byte_ready), .hit(hit),
    .hit_cnt(hit_cnt), .busy(busy), .done(done)
  );

  // ---------------- scoreboard ----------------
  // entry = {byte_ready, busy, done, hit, hit_cnt[7:0]}
  logic [11:0] exp_q[$];
  int          n_checks = 0;
  int          n_fail   = 0;

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    logic [11:0] e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check("byte_ready", {7'd0, byte_ready}, {7'd0, e[11]});
      check("busy",       {7'd0, busy},       {7'd0, e[10]});
      check("done",       {7'd0, done},       {7'd0, e[9]});
      check("hit",        {7'd0, hit},        {7'd0, e[8]});
      check("hit_cnt",    hit_cnt,            e[7:0]);
    end
  end

  // ---------------- reference model ----------------
  logic       m_hit;
  logic [7:0] m_cnt;
  logic [7:0] job_bytes[16];
  int         job_gap[16];
  logic       job_bits[128];

  // Bit k matches when the L most recent bits (bit k newest = pattern bit 0) equal the pattern.
  function automatic bit model_match(input int k, input int len, input logic [3:0] pat);
    if (k + 1 < len) return 1'b0;
    for (int j = 0; j < len; j++)
      if (job_bits[k-j] !== pat[j]) return 1'b0;
    return 1'b1;
  endfunction

  // ---------------- driver ----------------
  task automatic cyc(input logic st, input logic bv, input logic [7:0] b,
                     input logic e_br, input logic e_busy, input logic e_done);
    @(posedge clk);
    #1;
    start      = st;
    byte_valid = bv;
    byte_in    = b;
    exp_q.push_back({e_br, e_busy, e_done, m_hit, m_cnt});
  endtask

  task automatic scramble(input bit noise);
    if (noise) begin
      cfg_pat    = 4'($urandom);
      cfg_len    = 3'($urandom);
      cfg_nbytes = 4'($urandom);
    end
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) cyc(1'b0, 1'($urandom), 8'($urandom), 1'b0, 1'b0, 1'b0);
  endtask

  task automatic run_job(input logic [3:0] pat, input logic [2:0] len_raw,
                         input logic [3:0] nb_raw, input bit noise, output int final_cnt);
    int len, nb, k;
    len = (len_raw >= 1 && len_raw <= 4) ? int'(len_raw) : 4;
    nb  = (nb_raw == 0) ? 16 : int'(nb_raw);
    for (int i = 0; i < nb; i++)
      for (int b = 0; b < 8; b++) job_bits[i*8+b] = job_bytes[i][7-b];
    cyc(1'b1, 1'b0, 8'($urandom), 1'b0, 1'b0, 1'b0);
    cfg_pat = pat; cfg_len = len_raw; cfg_nbytes = nb_raw;
    m_hit = 1'b0; m_cnt = 8'd0;
    for (int i = 0; i < nb; i++) begin
      for (int g = 0; g < job_gap[i]; g++) begin
        cyc(noise & 1'($urandom), 1'b0, 8'($urandom), 1'b1, 1'b1, 1'b0);
        scramble(noise);
        m_hit = 1'b0;
      end
      cyc(noise & 1'($urandom), 1'b1, job_bytes[i], 1'b1, 1'b1, 1'b0);
      scramble(noise);
      m_hit = 1'b0;
      for (int b = 0; b < 8; b++) begin
        cyc(noise & 1'($urandom), noise & 1'($urandom), 8'($urandom), 1'b0, 1'b1, 1'b0);
        scramble(noise);
        k = i*8 + b;
        m_hit = model_match(k, len, pat);
        if (m_hit && m_cnt != 8'hFF) m_cnt = m_cnt + 8'd1;
      end
    end
    cyc(noise & 1'($urandom), 1'b0, 8'($urandom), 1'b0, 1'b0, 1'b1);
    m_hit = 1'b0;
    final_cnt = int'(m_cnt);
    idle_cycles(2);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_byte_ready"}, {7'd0, byte_ready}, 8'd0);
    check({tag, "_busy"},       {7'd0, busy},       8'd0);
    check({tag, "_done"},       {7'd0, done},       8'd0);
    check({tag, "_hit"},        {7'd0, hit},        8'd0);
    check({tag, "_hit_cnt"},    hit_cnt,            8'd0);
  endtask

  task automatic clear_job(input logic [7:0] fill);
    for (int i = 0; i < 16; i++) begin
      job_bytes[i] = fill;
      job_gap[i]   = 0;
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int cnt;
    rst_n = 1'b0; start = 1'b0; byte_valid = 1'b0; byte_in = 8'd0;
    cfg_pat = 4'd0; cfg_len = 3'd0; cfg_nbytes = 4'd0;
    m_hit = 1'b0; m_cnt = 8'd0;
    #2;
    check_all_zero("reset");
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    idle_cycles(3);

    // all-zero pattern: hits after bits 4..8
    clear_job(8'h00);
    run_job(4'b0000, 3'd4, 4'd1, 1'b0, cnt);
    check("pin_zero_pat", 8'(cnt), 8'd5);

    // 1010 across a byte boundary
    clear_job(8'h00);
    job_bytes[0] = 8'h0A; job_bytes[1] = 8'hA0;
    run_job(4'b1010, 3'd4, 4'd2, 1'b0, cnt);
    check("pin_1010", 8'(cnt), 8'd3);

    // same job, 5-cycle stall before byte 2, start/cfg noise while busy
    job_gap[1] = 5;
    run_job(4'b1010, 3'd4, 4'd2, 1'b1, cnt);
    check("pin_1010_stall", 8'(cnt), 8'd3);

    // single-bit pattern, 16 bytes of ones
    clear_job(8'hFF);
    run_job(4'b0101, 3'd1, 4'd0, 1'b0, cnt);
    check("pin_ones", 8'(cnt), 8'd128);

    // overlapping: pattern 11, input 111 -> 2 hits
    clear_job(8'h00);
    job_bytes[0] = 8'b0111_0000;
    run_job(4'b0011, 3'd2, 4'd1, 1'b0, cnt);
    check("pin_overlap", 8'(cnt), 8'd2);

    // out-of-range lengths behave as 4
    clear_job(8'h00);
    job_bytes[0] = 8'b1101_1011;
    run_job(4'b1011, 3'd0, 4'd1, 1'b0, cnt);
    check("pin_len0", 8'(cnt), 8'd2);
    run_job(4'b1011, 3'd7, 4'd1, 1'b0, cnt);
    check("pin_len7", 8'(cnt), 8'd2);

    // abort in the middle of byte 1's shift
    clear_job(8'hFF);
    cyc(1'b1, 1'b0, 8'd0, 1'b0, 1'b0, 1'b0);
    cfg_pat = 4'b0001; cfg_len = 3'd1; cfg_nbytes = 4'd2;
    m_hit = 1'b0; m_cnt = 8'd0;
    cyc(1'b0, 1'b1, 8'hFF, 1'b1, 1'b1, 1'b0);
    cyc(1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
    m_hit = 1'b1; m_cnt = 8'd1;
    cyc(1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
    m_hit = 1'b1; m_cnt = 8'd2;
    cyc(1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
    #2;
    rst_n = 1'b0;
    exp_q.delete();
    #1;
    check_all_zero("abort");
    repeat (2) @(posedge clk);
    #1;
    check_all_zero("abort_hold");
    rst_n = 1'b1;
    m_hit = 1'b0; m_cnt = 8'd0;
    idle_cycles(12);
    clear_job(8'h00);
    job_bytes[0] = 8'h0A; job_bytes[1] = 8'hA0;
    run_job(4'b1010, 3'd4, 4'd2, 1'b0, cnt);
    check("pin_after_abort", 8'(cnt), 8'd3);

    // randomized jobs
    for (int j = 0; j < 24; j++) begin
      for (int i = 0; i < 16; i++) begin
        job_bytes[i] = 8'($urandom);
        job_gap[i]   = $urandom_range(0, 3);
      end
      run_job(4'($urandom), 3'($urandom), 4'($urandom), bit'($urandom_range(0, 1)), cnt);
      idle_cycles($urandom_range(0, 3));
    end

    repeat (3) @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    n_fail++;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $fatal(1, "watchdog");
  end

endmodule
